pipe_stage_skid: RTL and testbench
==================================

# pipe_stage_skid

Parametrised pipeline-stage register with a valid/ready handshake, a 2-entry skid buffer, synchronous flush and a stall counter. It supersedes the fixed-field stage latches between pipeline stages: a whole stage bundle is packed into one payload bus. The stage sustains one transfer per cycle with no combinational path from input to output or from out_ready to in_ready. A flushed or empty stage presents an all-zero bubble, so control bits such as RegWrite read 0.

## Interface
- PAYLOAD_W, 153: payload width in bits (the MEM/WB bundle is 153 bits).
- CNT_W, 16: stall counter width.

- clk  in  1  clock; all state updates on posedge.
- reset  in  1  asynchronous, active-low.
- flush  in  1  synchronous kill of stage contents; highest priority.
- in_valid  in  1  upstream bundle valid.
- in_ready  out  1  stage can accept; driven from registered state only.
- in_data  in  PAYLOAD_W  upstream bundle.
- out_valid  out  1  main register holds a valid bundle.
- out_ready  in  1  downstream accepts.
- out_data  out  PAYLOAD_W  main register contents; all-zero when out_valid=0.
- stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0, saturating.

## Operation
- Handshakes:
  - in_fire = in_valid & in_ready.
  - out_fire = out_valid & out_ready.
- Storage: main register (drives out_data) and skid register. State is EMPTY, ONE or TWO.
- in_ready = (state != TWO). out_valid = (state != EMPTY).
- EMPTY:
  - in_fire -> ONE, main <= in_data.
- ONE:
  - in_fire & out_fire -> ONE, main <= in_data.
  - in_fire & !out_fire -> TWO, skid <= in_data.
  - !in_fire & out_fire -> EMPTY, main <= 0.
  - neither -> hold.
- TWO (in_ready=0, in_data ignored):
  - out_fire -> ONE, main <= skid, skid <= 0.
  - else hold.
- flush=1 at an edge:
  - state -> EMPTY; main and skid <= 0.
  - Any in_fire or out_fire in that cycle is discarded: the upstream handshake completes, the data is dropped.
  - stall_cnt is unaffected.
- Ordering: strictly FIFO. The skid entry is always older than any newer input.
- stall_cnt:
  - +1 on each edge where out_valid & !out_ready & !flush.
  - Saturates at 2^CNT_W-1; no wrap.
  - Cleared only by reset.
- Reset asserted (asynchronous):
  - state EMPTY; main, skid <= 0; stall_cnt 0.
  - Outputs: out_valid 0, out_data 0, in_ready 1.
  - Upstream must hold in_valid low while reset is low.
- Reset mid-operation: contents are lost immediately, no drain. After release the stage behaves exactly as after power-on.

## Timing
- Latency: in_fire at edge N -> out_valid=1 with that bundle after edge N (1 cycle).
- Throughput: 1 bundle/cycle while out_ready=1.
- Back-pressure: out_ready dropping takes effect on in_ready one cycle later. The skid register absorbs the one extra accepted bundle.
- out_ready rising in TWO: out_fire at that edge; in_ready=1 after that edge.
- Registered outputs: out_valid, out_data, in_ready, stall_cnt are all flop outputs. No combinational path from any input to any output.
- flush: takes effect at the next edge. out_valid=0, in_ready=1 after that edge.
- Simultaneous flush and reset low: reset wins.

## Test plan
- Reset: drive reset=0 mid-stream with state TWO -> out_valid=0, out_data=0, in_ready=1, stall_cnt=0 without waiting for a clock edge.
- Streaming: out_ready=1; in_data=1,2,3... each cycle -> out_data=1,2,3... each one cycle late; in_ready stays 1; stall_cnt stays 0.
- Back-pressure:
  - Accept A=0xA, then B=0xB with out_ready=0 -> state TWO, in_ready=0, out_data=0xA.
  - stall_cnt increments each held cycle.
  - Raise out_ready -> 0xA then 0xB delivered; nothing lost or duplicated.
- Flush: in state TWO with in_valid=1, assert flush for one cycle -> next cycle out_valid=0, out_data=0, in_ready=1; 0xA, 0xB and the flushed input never appear.
- Saturation: CNT_W=4; hold out_valid=1, out_ready=0 for 20 cycles -> stall_cnt reaches 15 and stays 15.
- Width: PAYLOAD_W=1 and PAYLOAD_W=153 -> streaming and back-pressure scenarios pass unchanged.

Source files
------------

// File: rtl/pipe_stage_skid.sv
// Pipeline-stage register with valid/ready handshake, 2-entry skid buffer,
// synchronous flush and a saturating stall counter. Empty or flushed stages
// present an all-zero bubble on out_data.
module pipe_stage_skid #(
    parameter int unsigned PAYLOAD_W = 153,
    parameter int unsigned CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [PAYLOAD_W-1:0] in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [PAYLOAD_W-1:0] out_data,
    output logic [CNT_W-1:0]     stall_cnt
);

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_TWO   = 2'd2;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [1:0]           state_q,     state_d;
    logic [PAYLOAD_W-1:0] main_q,      main_d;
    logic [PAYLOAD_W-1:0] skid_q,      skid_d;
    logic [CNT_W-1:0]     cnt_q,       cnt_d;
    logic                 in_ready_q,  in_ready_d;
    logic                 out_valid_q, out_valid_d;
    logic                 in_fire;
    logic                 out_fire;

    // State, storage and registered handshake outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_EMPTY;
            main_q      <= '0;
            skid_q      <= '0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            main_q      <= main_d;
            skid_q      <= skid_d;
            cnt_q       <= cnt_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    // Next-state, data movement, flush override and stall counting
    always_comb begin
        state_d  = state_q;
        main_d   = main_q;
        skid_d   = skid_q;
        cnt_d    = cnt_q;
        in_fire  = in_valid & in_ready_q;
        out_fire = out_valid_q & out_ready;

        case (state_q)
            ST_EMPTY: begin
                if (in_fire) begin
                    state_d = ST_ONE;
                    main_d  = in_data;
                end
            end
            ST_ONE: begin
                if (in_fire && out_fire) begin
                    main_d = in_data;
                end else if (in_fire) begin
                    state_d = ST_TWO;
                    skid_d  = in_data;
                end else if (out_fire) begin
                    state_d = ST_EMPTY;
                    main_d  = '0;
                end
            end
            ST_TWO: begin
                // in_ready is low here, so in_data is ignored; skid is the older entry
                if (out_fire) begin
                    state_d = ST_ONE;
                    main_d  = skid_q;
                    skid_d  = '0;
                end
            end
            default: begin
                state_d = ST_EMPTY;
                main_d  = '0;
                skid_d  = '0;
            end
        endcase

        // Flush drops contents and any handshake completing this cycle
        if (flush) begin
            state_d = ST_EMPTY;
            main_d  = '0;
            skid_d  = '0;
        end

        if (out_valid_q && !out_ready && !flush && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        out_valid_d = (state_d != ST_EMPTY);
        in_ready_d  = (state_d != ST_TWO);
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = main_q;
    assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed bench for pipe_stage_skid: a 153-bit/4-bit-counter instance and a
// 1-bit payload instance share stimulus.
module tb_pipe_stage_skid;

    localparam int unsigned PW    = 153;
    localparam int unsigned CW    = 4;
    localparam int unsigned CW1   = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          flush;
    logic          in_valid;
    logic [PW-1:0] in_data;
    logic          out_ready;

    logic          in_ready,  out_valid;
    logic [PW-1:0] out_data;
    logic [CW-1:0] stall_cnt;

    logic           in_ready1, out_valid1;
    logic [0:0]     out_data1;
    logic [CW1-1:0] stall_cnt1;

    int n_assert = 0;
    int n_fail   = 0;

    pipe_stage_skid #(.PAYLOAD_W(PW), .CNT_W(CW)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .stall_cnt (stall_cnt)
    );

    pipe_stage_skid #(.PAYLOAD_W(1), .CNT_W(CW1)) dut1 (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready1),
        .in_data   (in_data[0:0]),
        .out_valid (out_valid1),
        .out_ready (out_ready),
        .out_data  (out_data1),
        .stall_cnt (stall_cnt1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one edge and settle away from it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [PW-1:0] pat(input int v);
        return (PW'(v) << 145) | PW'(v);
    endfunction

    // Full output check on both instances (stall count only on the 4-bit one)
    task automatic chk_all(input string tag, input logic ev, input logic er,
                           input logic [PW-1:0] ed, input int ec);
        chk({tag, ".out_valid"}, PW'(out_valid), PW'(ev));
        chk({tag, ".in_ready"},  PW'(in_ready),  PW'(er));
        chk({tag, ".out_data"},  out_data,       ed);
        chk({tag, ".stall_cnt"}, PW'(stall_cnt), PW'(ec));
        chk({tag, ".w1_valid"},  PW'(out_valid1), PW'(ev));
        chk({tag, ".w1_ready"},  PW'(in_ready1),  PW'(er));
        chk({tag, ".w1_data"},   PW'(out_data1),  PW'(ed[0]));
    endtask

    initial begin
        logic [PW-1:0] a, b, c;
        a = pat(32'hA);
        b = pat(32'hB);
        c = pat(32'hC);

        // Power-on reset
        reset = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        #12;
        chk_all("reset", 1'b0, 1'b1, '0, 0);
        @(negedge clk);
        reset = 1'b1;
        step();
        chk_all("idle", 1'b0, 1'b1, '0, 0);

        // Streaming: one-cycle latency, full throughput
        out_ready = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            in_valid = 1'b1;
            in_data  = pat(i);
            step();
            chk_all($sformatf("stream%0d", i), 1'b1, 1'b1, pat(i), 0);
        end
        in_valid = 1'b0;
        step();
        chk_all("stream_drain", 1'b0, 1'b1, '0, 0);

        // Back-pressure: A then B while downstream stalls
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = a;
        step();
        chk_all("bp_a", 1'b1, 1'b1, a, 0);
        in_data = b;
        step();
        chk_all("bp_two", 1'b1, 1'b0, a, 1);
        in_valid = 1'b0; in_data = c;
        step();
        chk_all("bp_hold", 1'b1, 1'b0, a, 2);
        out_ready = 1'b1;
        step();
        chk_all("bp_deliver_b", 1'b1, 1'b1, b, 2);
        step();
        chk_all("bp_empty", 1'b0, 1'b1, '0, 2);

        // Flush from TWO with an input offered
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = a;
        step();
        in_data = b;
        step();
        chk_all("fl_two", 1'b1, 1'b0, a, 3);
        in_data = c; flush = 1'b1;
        step();
        chk_all("fl_after", 1'b0, 1'b1, '0, 3);
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        step();
        chk_all("fl_nothing", 1'b0, 1'b1, '0, 3);

        // Stall counter saturation at 15
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = pat(32'h55);
        step();
        chk_all("sat_load", 1'b1, 1'b1, pat(32'h55), 3);
        in_valid = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            step();
            if (i == 5)  chk("sat_mid",  PW'(stall_cnt), PW'(8));
            if (i == 12) chk("sat_hit",  PW'(stall_cnt), PW'(15));
        end
        chk("sat_stay", PW'(stall_cnt), PW'(15));
        chk("sat_w1", PW'(stall_cnt1), PW'(3 + 20));

        // Asynchronous reset while in TWO
        in_valid = 1'b1; in_data = pat(32'h66);
        step();
        chk_all("rst_two", 1'b1, 1'b0, pat(32'h55), 15);
        in_valid = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        chk_all("rst_async", 1'b0, 1'b1, '0, 0);
        chk("rst_w1_cnt", PW'(stall_cnt1), '0);
        @(negedge clk);
        reset = 1'b1;

        // Post-reset behaviour matches power-on
        out_ready = 1'b1; in_valid = 1'b1; in_data = pat(7);
        step();
        chk_all("post_rst", 1'b1, 1'b1, pat(7), 0);
        in_valid = 1'b0;
        step();
        chk_all("post_rst_drain", 1'b0, 1'b1, '0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
